// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared state encoding and command-byte layout for the SPI register bank.
package spi_reg_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DISCARD} state_t;
  localparam int CMD_WR_BIT = 7;
  localparam int CMD_ADDR_W = 7;
  localparam logic [7:0] DEF_ID_BYTE = 8'hA5;
endpackage

// File: rtl/spi_frame_timer.sv
// spi_frame_timer: idle-cycle counter that closes an open frame after TIMEOUT quiet cycles.
module spi_frame_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  assign expire = enable && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (!enable || clear || expire) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI byte-stream command decoder and 8-bit register file.
// SPI_REG_AUTOINC_EN enables per-byte address auto-increment with wrap.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter int         ADDR_W   = 7,
  parameter int         TIMEOUT  = 1024,
  parameter logic [7:0] ID_BYTE  = DEF_ID_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  frame_active,
  output logic                  err
);
  localparam int AW = $clog2(NUM_REGS);
  state_t        state;
  logic [AW-1:0] addr;
  logic [7:0]    reg_q [NUM_REGS];
  logic          expire, out_range;
  assign frame_active = state != IDLE;
  assign out_range = 32'(rx_data[CMD_ADDR_W-1:0]) >= NUM_REGS;
  assign tx_data = state == READ ? reg_q[addr] : ID_BYTE;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[8*g +: 8] = reg_q[g];
  end
`ifdef SPI_REG_AUTOINC_EN
  logic [AW-1:0] next_addr;
  assign next_addr = addr == AW'(NUM_REGS - 1) ? '0 : addr + 1'b1;
`endif
  spi_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (frame_active),
    .clear  (rx_valid),
    .expire (expire)
  );
  // A byte arriving on the expiry cycle wins: it is processed and the frame stays open.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      err       <= 1'b0;
      if (rx_valid && state == IDLE) begin
        addr  <= AW'(rx_data[CMD_ADDR_W-1:0]);
        state <= out_range ? DISCARD : rx_data[CMD_WR_BIT] ? WRITE : READ;
        err   <= out_range;
      end else if (rx_valid) begin
        if (state == WRITE) begin
          reg_q[addr] <= rx_data;
          wr_strobe   <= 1'b1;
          wr_addr     <= ADDR_W'(addr);
        end
`ifdef SPI_REG_AUTOINC_EN
        if (state != DISCARD) addr <= next_addr;
`endif
      end else if (expire) state <= IDLE;
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: table-driven frames plus write scoreboard for spi_reg_bank.
module tb_spi_reg_bank;
  localparam int TO = 16;
`ifdef SPI_REG_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif
  logic         clk = 0, rst = 0, rx_valid = 0;
  logic [7:0]   rx_data = 0, tx_data;
  logic [127:0] regs;
  logic         wr_strobe, frame_active, err;
  logic [6:0]   wr_addr;
  typedef struct {int gap; logic pre_fa; logic [7:0] rx; logic [7:0] tx; logic fa; logic er; logic wr; logic [6:0] wa;} vec_t;
  typedef struct {logic [6:0] a; logic [7:0] d;} wr_t;
  vec_t vecs[12];
  wr_t  sbq[$];
  logic [7:0] model[16];
  int n_cmp = 0, n_bad = 0;

  spi_reg_bank #(.NUM_REGS(16), .ADDR_W(7), .TIMEOUT(TO), .ID_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_active(frame_active), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_check();
    wr_t e;
    if (wr_strobe) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got wr_addr %h expected no write", wr_addr);
      end else begin
        e = sbq.pop_front();
        chk("sb_wr_addr", 32'(wr_addr), 32'(e.a));
        chk("sb_wr_data", 32'(regs[8*wr_addr +: 8]), 32'(e.d));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [6:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sbq.push_back(w);
    model[a[3:0]] = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    vecs[0]  = '{0,  1'b0, 8'h83, 8'hA5, 1'b1, 1'b0, 1'b0, 7'd0};
    vecs[1]  = '{0,  1'b1, 8'h11, 8'hA5, 1'b1, 1'b0, 1'b1, 7'd3};
    vecs[2]  = '{2,  1'b1, 8'h22, 8'hA5, 1'b1, 1'b0, 1'b1, AI ? 7'd4 : 7'd3};
    vecs[3]  = '{TO, 1'b0, 8'h03, AI ? 8'h11 : 8'h22, 1'b1, 1'b0, 1'b0, 7'd0};
    vecs[4]  = '{1,  1'b1, 8'h00, 8'h22, 1'b1, 1'b0, 1'b0, 7'd0};
    vecs[5]  = '{TO, 1'b0, 8'h8F, 8'hA5, 1'b1, 1'b0, 1'b0, 7'd0};
    vecs[6]  = '{0,  1'b1, 8'hAA, 8'hA5, 1'b1, 1'b0, 1'b1, 7'd15};
    vecs[7]  = '{0,  1'b1, 8'hBB, 8'hA5, 1'b1, 1'b0, 1'b1, AI ? 7'd0 : 7'd15};
    vecs[8]  = '{TO, 1'b0, 8'hC0, 8'hA5, 1'b1, 1'b1, 1'b0, 7'd0};
    vecs[9]  = '{0,  1'b1, 8'h55, 8'hA5, 1'b1, 1'b0, 1'b0, 7'd0};
    vecs[10] = '{TO, 1'b0, 8'h0F, AI ? 8'hAA : 8'hBB, 1'b1, 1'b0, 1'b0, 7'd0};
    vecs[11] = '{0,  1'b1, 8'h00, 8'hBB, 1'b1, 1'b0, 1'b0, 7'd0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_regs_zero", 32'(|regs), 32'd0);
    chk("rst_tx", 32'(tx_data), 32'hA5);
    chk("rst_fa", 32'(frame_active), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      repeat (vecs[i].gap) tick();
      chk($sformatf("v%0d_pre_fa", i), 32'(frame_active), 32'(vecs[i].pre_fa));
      if (vecs[i].wr) expect_write(vecs[i].wa, vecs[i].rx);
      send(vecs[i].rx);
      chk($sformatf("v%0d_tx", i), 32'(tx_data), 32'(vecs[i].tx));
      chk($sformatf("v%0d_fa", i), 32'(frame_active), 32'(vecs[i].fa));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].er));
      chk($sformatf("v%0d_sb_drained", i), sbq.size(), 32'd0);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("reg%0d", i), 32'(regs[8*i +: 8]), 32'(model[i]));
    chk("reg15_wrap", 32'(regs[127:120]), AI ? 32'hAA : 32'hBB);
    chk("reg0_wrap", 32'(regs[7:0]), AI ? 32'hBB : 32'h00);
    // Byte on the exact expiry cycle keeps the frame open.
    repeat (TO) tick();
    chk("race_idle", 32'(frame_active), 32'd0);
    send(8'h81);
    repeat (TO - 1) tick();
    chk("race_pre_expiry_fa", 32'(frame_active), 32'd1);
    expect_write(7'd1, 8'h77);
    send(8'h77);
    chk("race_fa_held", 32'(frame_active), 32'd1);
    chk("race_reg1", 32'(regs[15:8]), 32'h77);
    chk("race_sb_drained", sbq.size(), 32'd0);
    repeat (TO - 1) tick();
    chk("race_fa_before_close", 32'(frame_active), 32'd1);
    tick();
    chk("race_fa_closed", 32'(frame_active), 32'd0);
    // Asynchronous reset between data bytes of a write frame.
    send(8'h82);
    expect_write(7'd2, 8'h44);
    send(8'h44);
    chk("mid_reg2", 32'(regs[23:16]), 32'h44);
    rst = 1'b0;
    #2;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk("arst_regs_zero", 32'(|regs), 32'd0);
    chk("arst_fa", 32'(frame_active), 32'd0);
    chk("arst_tx", 32'(tx_data), 32'hA5);
    #2;
    rst = 1'b1;
    send(8'h05);
    chk("post_rst_fa", 32'(frame_active), 32'd1);
    chk("post_rst_read_tx", 32'(tx_data), 32'h00);
    chk("post_rst_err", 32'(err), 32'd0);
    send(8'h33);
    chk("post_rst_reg5", 32'(regs[47:40]), 32'h00);
    chk("post_rst_tx2", 32'(tx_data), 32'h00);
    chk("final_sb_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
